// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the core-to-UART AXI4-Lite bridge.
// The DRAIN state only exists when UART_BRIDGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
package uart_bridge_pkg;

    localparam int unsigned UART_ADDR_W = 13;
    localparam int unsigned UART_DATA_W = 32;
    localparam int unsigned UART_STRB_W = 4;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_AR,
        RD_R,
        RESP
`ifdef UART_BRIDGE_TIMEOUT_EN
        , DRAIN
`endif
    } bridge_state_t;

    // A request may touch only one 32-bit lane and must enable at least one byte.
    function automatic logic be_illegal(input logic [7:0] be);
        return (be == 8'h00) || ((|be[7:4]) && (|be[3:0]));
    endfunction

endpackage

// File: rtl/bridge_watchdog.sv
// Clear/enable cycle counter with a terminal-count pulse for the UART bridge.
// Only instantiated when UART_BRIDGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module bridge_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // The cycle in which clear is high already counts as the first waited cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= CW'(1);
        end else if (enable && (count != CW'(LIMIT))) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable & ~clear & (count == CW'(LIMIT - 1));

endmodule

// File: rtl/uart_axil_bridge.sv
// Core uncached request to AXI4-Lite bridge for the UART-Lite slave.
// Define UART_BRIDGE_TIMEOUT_EN to add watchdog recovery through a DRAIN state.
`timescale 1ns/1ps
module uart_axil_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned REQ_ADDR_WIDTH = 40,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [REQ_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [63:0]               req_wdata_i,
    input  logic [7:0]                req_be_i,
    output logic                      resp_valid_o,
    output logic [63:0]               resp_rdata_o,
    output logic                      resp_err_o,
    output logic [UART_ADDR_W-1:0]    m_axi_uart_awaddr,
    output logic [2:0]                m_axi_uart_awprot,
    output logic                      m_axi_uart_awvalid,
    input  logic                      m_axi_uart_awready,
    output logic [UART_DATA_W-1:0]    m_axi_uart_wdata,
    output logic [UART_STRB_W-1:0]    m_axi_uart_wstrb,
    output logic                      m_axi_uart_wvalid,
    input  logic                      m_axi_uart_wready,
    input  logic [1:0]                m_axi_uart_bresp,
    input  logic                      m_axi_uart_bvalid,
    output logic                      m_axi_uart_bready,
    output logic [UART_ADDR_W-1:0]    m_axi_uart_araddr,
    output logic [2:0]                m_axi_uart_arprot,
    output logic                      m_axi_uart_arvalid,
    input  logic                      m_axi_uart_arready,
    input  logic [UART_DATA_W-1:0]    m_axi_uart_rdata,
    input  logic [1:0]                m_axi_uart_rresp,
    input  logic                      m_axi_uart_rvalid,
    output logic                      m_axi_uart_rready
);

    bridge_state_t state;

    logic lane;
    logic accept;
    logic aw_done;
    logic w_done;

    assign lane    = req_addr_i[2];
    assign accept  = req_valid_i & req_ready_o;
    assign aw_done = ~m_axi_uart_awvalid | m_axi_uart_awready;
    assign w_done  = ~m_axi_uart_wvalid | m_axi_uart_wready;

    assign m_axi_uart_awprot = 3'b000;
    assign m_axi_uart_arprot = 3'b000;

    logic unused_ok;
    assign unused_ok = ^{req_addr_i[REQ_ADDR_WIDTH-1:UART_ADDR_W], req_addr_i[1:0]};

`ifdef UART_BRIDGE_TIMEOUT_EN
    bridge_state_t prev_state;
    logic          wd_expired;
    logic          drain_b;
    logic          drain_r;

    // Watchdog restarts whenever the FSM lands in a new state.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) prev_state <= IDLE;
        else         prev_state <= state;
    end

    bridge_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk_i),
        .rstn    (rstn_i),
        .clear   (state != prev_state),
        .enable  (state inside {WR, WR_B, RD_AR, RD_R}),
        .expired (wd_expired)
    );
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES < 2);
`endif

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state              <= IDLE;
            req_ready_o        <= 1'b0;
            resp_valid_o       <= 1'b0;
            resp_err_o         <= 1'b0;
            resp_rdata_o       <= '0;
            m_axi_uart_awaddr  <= '0;
            m_axi_uart_araddr  <= '0;
            m_axi_uart_wdata   <= '0;
            m_axi_uart_wstrb   <= '0;
            m_axi_uart_awvalid <= 1'b0;
            m_axi_uart_wvalid  <= 1'b0;
            m_axi_uart_bready  <= 1'b0;
            m_axi_uart_arvalid <= 1'b0;
            m_axi_uart_rready  <= 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            drain_b            <= 1'b0;
            drain_r            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (accept) begin
                        req_ready_o       <= 1'b0;
                        resp_err_o        <= 1'b0;
                        m_axi_uart_awaddr <= {req_addr_i[UART_ADDR_W-1:2], 2'b00};
                        m_axi_uart_araddr <= {req_addr_i[UART_ADDR_W-1:2], 2'b00};
                        m_axi_uart_wdata  <= lane ? req_wdata_i[63:32] : req_wdata_i[31:0];
                        m_axi_uart_wstrb  <= lane ? req_be_i[7:4] : req_be_i[3:0];
                        if (be_illegal(req_be_i)) begin
                            resp_err_o <= 1'b1;
                            state      <= RESP;
                        end else if (req_we_i) begin
                            m_axi_uart_awvalid <= 1'b1;
                            m_axi_uart_wvalid  <= 1'b1;
                            state              <= WR;
                        end else begin
                            m_axi_uart_arvalid <= 1'b1;
                            state              <= RD_AR;
                        end
                    end
                end

                // AW and W complete independently; B is only opened once both are done.
                WR: begin
                    if (m_axi_uart_awready) m_axi_uart_awvalid <= 1'b0;
                    if (m_axi_uart_wready)  m_axi_uart_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axi_uart_bready <= 1'b1;
                        state             <= WR_B;
                    end
`ifdef UART_BRIDGE_TIMEOUT_EN
                    else if (wd_expired) begin
                        resp_valid_o      <= 1'b1;
                        resp_err_o        <= 1'b1;
                        m_axi_uart_bready <= 1'b1;
                        drain_b           <= 1'b1;
                        state             <= DRAIN;
                    end
`endif
                end

                WR_B: begin
                    if (m_axi_uart_bvalid) begin
                        m_axi_uart_bready <= 1'b0;
                        resp_err_o        <= (m_axi_uart_bresp != AXI_RESP_OKAY);
                        resp_valid_o      <= 1'b1;
                        state             <= RESP;
                    end
`ifdef UART_BRIDGE_TIMEOUT_EN
                    else if (wd_expired) begin
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        drain_b      <= 1'b1;
                        state        <= DRAIN;
                    end
`endif
                end

                RD_AR: begin
                    if (m_axi_uart_arready) begin
                        m_axi_uart_arvalid <= 1'b0;
                        m_axi_uart_rready  <= 1'b1;
                        state              <= RD_R;
                    end
`ifdef UART_BRIDGE_TIMEOUT_EN
                    else if (wd_expired) begin
                        resp_valid_o      <= 1'b1;
                        resp_err_o        <= 1'b1;
                        m_axi_uart_rready <= 1'b1;
                        drain_r           <= 1'b1;
                        state             <= DRAIN;
                    end
`endif
                end

                RD_R: begin
                    if (m_axi_uart_rvalid) begin
                        m_axi_uart_rready <= 1'b0;
                        resp_rdata_o      <= {m_axi_uart_rdata, m_axi_uart_rdata};
                        resp_err_o        <= (m_axi_uart_rresp != AXI_RESP_OKAY);
                        resp_valid_o      <= 1'b1;
                        state             <= RESP;
                    end
`ifdef UART_BRIDGE_TIMEOUT_EN
                    else if (wd_expired) begin
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        drain_r      <= 1'b1;
                        state        <= DRAIN;
                    end
`endif
                end

                // Illegal requests arrive here with the pulse not yet raised, so they spend one extra cycle.
                RESP: begin
                    if (resp_valid_o) begin
                        resp_valid_o <= 1'b0;
                        resp_err_o   <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        resp_valid_o <= 1'b1;
                    end
                end

`ifdef UART_BRIDGE_TIMEOUT_EN
                // Finish every outstanding handshake and silently discard the late response.
                DRAIN: begin
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    if (m_axi_uart_awready) m_axi_uart_awvalid <= 1'b0;
                    if (m_axi_uart_wready)  m_axi_uart_wvalid  <= 1'b0;
                    if (m_axi_uart_arready) m_axi_uart_arvalid <= 1'b0;
                    if (m_axi_uart_bvalid && m_axi_uart_bready) begin
                        m_axi_uart_bready <= 1'b0;
                        drain_b           <= 1'b0;
                    end
                    if (m_axi_uart_rvalid && m_axi_uart_rready) begin
                        m_axi_uart_rready <= 1'b0;
                        drain_r           <= 1'b0;
                    end
                    if (!m_axi_uart_awvalid && !m_axi_uart_wvalid && !m_axi_uart_arvalid &&
                        !drain_b && !drain_r) begin
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axil_bridge.sv
// Directed self-checking bench for uart_axil_bridge with a hand-driven AXI4-Lite slave.
// The watchdog scenario runs only when UART_BRIDGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_uart_axil_bridge;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [39:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_be_i;
    logic        resp_valid_o;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;
    logic [12:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [12:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;
    int aw_hs = 0;
    int w_hs = 0;
    int valid_cycles = 0;
    int resp_pulses = 0;

    always #5 clk_i = ~clk_i;

    uart_axil_bridge #(.REQ_ADDR_WIDTH(40), .TIMEOUT_CYCLES(16)) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_we_i           (req_we_i),
        .req_addr_i         (req_addr_i),
        .req_wdata_i        (req_wdata_i),
        .req_be_i           (req_be_i),
        .resp_valid_o       (resp_valid_o),
        .resp_rdata_o       (resp_rdata_o),
        .resp_err_o         (resp_err_o),
        .m_axi_uart_awaddr  (awaddr),
        .m_axi_uart_awprot  (awprot),
        .m_axi_uart_awvalid (awvalid),
        .m_axi_uart_awready (awready),
        .m_axi_uart_wdata   (wdata),
        .m_axi_uart_wstrb   (wstrb),
        .m_axi_uart_wvalid  (wvalid),
        .m_axi_uart_wready  (wready),
        .m_axi_uart_bresp   (bresp),
        .m_axi_uart_bvalid  (bvalid),
        .m_axi_uart_bready  (bready),
        .m_axi_uart_araddr  (araddr),
        .m_axi_uart_arprot  (arprot),
        .m_axi_uart_arvalid (arvalid),
        .m_axi_uart_arready (arready),
        .m_axi_uart_rdata   (rdata),
        .m_axi_uart_rresp   (rresp),
        .m_axi_uart_rvalid  (rvalid),
        .m_axi_uart_rready  (rready)
    );

    // Handshake and pulse monitor, sampled at the active edge before the DUT updates.
    always @(posedge clk_i) begin
        if (rstn_i) begin
            aw_hs        += int'(awvalid & awready);
            w_hs         += int'(wvalid & wready);
            valid_cycles += int'(awvalid | wvalid | arvalid);
            resp_pulses  += int'(resp_valid_o);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [39:0] addr,
                                 input logic [63:0] data, input logic [7:0] be);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = data;
        req_be_i    = be;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        int aw0, w0, v0, r0;
        rstn_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
        req_wdata_i = '0; req_be_i = '0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;

        // Reset values
        tick(3);
        checkOutput("rst_req_ready", 64'(req_ready_o), 64'd0);
        checkOutput("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        checkOutput("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        checkOutput("rst_resp_err", 64'(resp_err_o), 64'd0);
        checkOutput("rst_rdata", resp_rdata_o, 64'd0);
        rstn_i = 1'b1;
        tick(1);
        checkOutput("post_rst_ready", 64'(req_ready_o), 64'd1);

        // Lower-lane write, zero-wait slave
        $display("[TB] write lower lane");
        awready = 1'b1; wready = 1'b1;
        applyStimulus(1'b1, 40'h00_0000_0000, 64'h0000_0000_0000_0041, 8'h0F);
        tick(1);
        req_valid_i = 1'b0;
        checkOutput("wr1_aw_w_valid", 64'({awvalid, wvalid}), 64'b11);
        checkOutput("wr1_awaddr", 64'(awaddr), 64'h000);
        checkOutput("wr1_wdata", 64'(wdata), 64'h41);
        checkOutput("wr1_wstrb", 64'(wstrb), 64'hF);
        checkOutput("wr1_prot", 64'({awprot, arprot}), 64'd0);
        checkOutput("wr1_ready_busy", 64'(req_ready_o), 64'd0);
        tick(1);
        checkOutput("wr1_c2_valids", 64'({awvalid, wvalid}), 64'b00);
        checkOutput("wr1_c2_bready", 64'(bready), 64'd1);
        checkOutput("wr1_c2_no_resp", 64'(resp_valid_o), 64'd0);
        bvalid = 1'b1; bresp = 2'b00;
        tick(1);
        checkOutput("wr1_c3_resp", 64'({resp_valid_o, resp_err_o}), 64'b10);
        checkOutput("wr1_c3_bready", 64'(bready), 64'd0);
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        tick(1);
        checkOutput("wr1_c4_idle", 64'({resp_valid_o, req_ready_o}), 64'b01);

        // Read with four wait cycles on rvalid
        $display("[TB] read with wait states");
        arready = 1'b1;
        applyStimulus(1'b0, 40'hFF_FFFF_E008, 64'h0, 8'h0F);
        tick(1);
        req_valid_i = 1'b0;
        checkOutput("rd_arvalid", 64'(arvalid), 64'd1);
        checkOutput("rd_araddr", 64'(araddr), 64'h008);
        tick(1);
        checkOutput("rd_c2", 64'({arvalid, rready}), 64'b01);
        arready = 1'b0;
        tick(4);
        checkOutput("rd_wait", 64'({rready, resp_valid_o}), 64'b10);
        rvalid = 1'b1; rdata = 32'h15; rresp = 2'b00;
        tick(1);
        checkOutput("rd_resp", 64'({resp_valid_o, resp_err_o, rready}), 64'b100);
        checkOutput("rd_rdata", resp_rdata_o, 64'h0000_0015_0000_0015);
        rvalid = 1'b0; rdata = '0;
        tick(1);
        checkOutput("rd_done", 64'({resp_valid_o, req_ready_o}), 64'b01);

        // Upper-lane write with AW accepted at cycle 1 and W at cycle 3
        $display("[TB] write upper lane, split handshakes");
        aw0 = aw_hs; w0 = w_hs;
        applyStimulus(1'b1, 40'hAB_CDE0_1004, 64'hDEAD_BEEF_0000_0041, 8'hF0);
        tick(1);
        req_valid_i = 1'b0;
        checkOutput("wr2_awaddr", 64'(awaddr), 64'h1004);
        checkOutput("wr2_wdata", 64'(wdata), 64'hDEAD_BEEF);
        checkOutput("wr2_wstrb", 64'(wstrb), 64'hF);
        awready = 1'b1;
        tick(1);
        checkOutput("wr2_c2", 64'({awvalid, wvalid, bready}), 64'b010);
        awready = 1'b0;
        tick(1);
        checkOutput("wr2_c3", 64'({awvalid, wvalid, bready}), 64'b010);
        wready = 1'b1;
        tick(1);
        checkOutput("wr2_c4", 64'({awvalid, wvalid, bready}), 64'b001);
        wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        tick(1);
        checkOutput("wr2_resp", 64'({resp_valid_o, resp_err_o}), 64'b10);
        checkOutput("wr2_aw_hs", 64'(aw_hs - aw0), 64'd1);
        checkOutput("wr2_w_hs", 64'(w_hs - w0), 64'd1);
        bvalid = 1'b0;
        tick(1);
        checkOutput("wr2_idle", 64'(req_ready_o), 64'd1);

        // Illegal enables, back-to-back
        $display("[TB] illegal requests back to back");
        v0 = valid_cycles;
        applyStimulus(1'b1, 40'h0, 64'h1234, 8'h18);
        tick(1);
        checkOutput("ill1_c1", 64'({req_ready_o, resp_valid_o}), 64'b00);
        applyStimulus(1'b0, 40'h10, 64'h0, 8'h00);
        tick(1);
        checkOutput("ill1_c2", 64'({resp_valid_o, resp_err_o, req_ready_o}), 64'b110);
        tick(1);
        checkOutput("ill1_c3", 64'({resp_valid_o, req_ready_o}), 64'b01);
        tick(1);
        req_valid_i = 1'b0;
        checkOutput("ill2_c1", 64'({req_ready_o, resp_valid_o}), 64'b00);
        tick(1);
        checkOutput("ill2_c2", 64'({resp_valid_o, resp_err_o}), 64'b11);
        tick(1);
        checkOutput("ill_no_axi", 64'(valid_cycles - v0), 64'd0);
        checkOutput("ill_idle", 64'(req_ready_o), 64'd1);

        // SLVERR on read
        $display("[TB] read slave error");
        arready = 1'b1;
        applyStimulus(1'b0, 40'h0C, 64'h0, 8'hF0);
        tick(1);
        req_valid_i = 1'b0;
        checkOutput("slv_araddr", 64'(araddr), 64'h00C);
        tick(1);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hA5; rresp = 2'b10;
        tick(1);
        checkOutput("slv_resp", 64'({resp_valid_o, resp_err_o}), 64'b11);
        checkOutput("slv_rdata", resp_rdata_o, 64'h0000_00A5_0000_00A5);
        rvalid = 1'b0; rresp = 2'b00;
        tick(1);

        // Reset while waiting for B
        $display("[TB] reset in WR_B");
        r0 = resp_pulses;
        awready = 1'b1; wready = 1'b1;
        applyStimulus(1'b1, 40'h0, 64'h77, 8'h0F);
        tick(1);
        req_valid_i = 1'b0;
        tick(1);
        checkOutput("rst_mid_bready", 64'(bready), 64'd1);
        rstn_i = 1'b0; awready = 1'b0; wready = 1'b0;
        tick(1);
        checkOutput("rst_mid_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        checkOutput("rst_mid_resp", 64'({resp_valid_o, req_ready_o}), 64'b00);
        rstn_i = 1'b1;
        tick(1);
        checkOutput("rst_mid_idle", 64'(req_ready_o), 64'd1);
        checkOutput("rst_mid_no_resp", 64'(resp_pulses - r0), 64'd0);

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Watchdog: AR never accepted, then late AR and R drained silently
        $display("[TB] watchdog timeout");
        r0 = resp_pulses;
        applyStimulus(1'b0, 40'h20, 64'h0, 8'h0F);
        tick(1);
        req_valid_i = 1'b0;
        tick(15);
        checkOutput("to_c16", 64'({resp_valid_o, arvalid}), 64'b01);
        tick(1);
        checkOutput("to_c17", 64'({resp_valid_o, resp_err_o, arvalid, rready, req_ready_o}), 64'b11110);
        tick(1);
        checkOutput("to_c18", 64'({resp_valid_o, arvalid}), 64'b01);
        arready = 1'b1;
        tick(1);
        checkOutput("to_ar_done", 64'(arvalid), 64'd0);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h99;
        tick(1);
        rvalid = 1'b0;
        checkOutput("to_drain_busy", 64'({rready, req_ready_o}), 64'b00);
        tick(2);
        checkOutput("to_idle", 64'(req_ready_o), 64'd1);
        checkOutput("to_one_pulse", 64'(resp_pulses - r0), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
